// File: rtl/write_pointer_ctrl_if.sv
// write_pointer_ctrl_if: producer-side write pointer and flag bundle for the async FIFO write domain
interface write_pointer_ctrl_if #(parameter int ADDR_WIDTH = 6);
  logic inc;
  logic ovf_clr;
  logic [ADDR_WIDTH:0] wq2_rptr;
  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic wclken;
  logic full;
  logic almost_full;
  logic [ADDR_WIDTH:0] wlevel;
  logic overflow;
  modport master(output inc, ovf_clr, wq2_rptr, input wptr, waddr, wclken, full, almost_full, wlevel, overflow);
  modport slave(input inc, ovf_clr, wq2_rptr, output wptr, waddr, wclken, full, almost_full, wlevel, overflow);
endinterface

// File: rtl/write_pointer_ctrl.sv
// write_pointer_ctrl: async FIFO write-domain binary/Gray pointer, full/almost_full, fill level and sticky overflow
module write_pointer_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int AFULL_THRESH = 56
) (
  input logic clk,
  input logic rst,
  write_pointer_ctrl_if.slave bus
);
  localparam int P = ADDR_WIDTH + 1;
  localparam logic [P-1:0] AF = AFULL_THRESH[P-1:0];
  logic [P-1:0] bin, bin_next, gray_next, rbin, level_next;
  logic full_next;
  for (genvar g = 0; g < P; g++) begin : g_rbin
    assign rbin[g] = ^bus.wq2_rptr[P-1:g];
  end
  assign bus.wclken = bus.inc & ~bus.full;
  assign bus.waddr = bin[ADDR_WIDTH-1:0];
  assign bin_next = bin + {{ADDR_WIDTH{1'b0}}, bus.wclken};
  assign gray_next = (bin_next >> 1) ^ bin_next;
  assign level_next = bin_next - rbin;
  // full when the write pointer is exactly one lap ahead of the synchronized read pointer
  assign full_next = gray_next == {~bus.wq2_rptr[P-1:P-2], bus.wq2_rptr[P-3:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      bus.wptr <= '0;
      bus.full <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.wlevel <= '0;
      bus.overflow <= 1'b0;
    end else begin
      bin <= bin_next;
      bus.wptr <= gray_next;
      bus.full <= full_next;
      bus.almost_full <= level_next >= AF;
      bus.wlevel <= level_next;
      bus.overflow <= (bus.inc & bus.full) | (bus.overflow & ~bus.ovf_clr);
    end
  end
endmodule
